data_mem_responder: RTL

//  Data-memory responder on the far end of the control unit's memory strobes (w_e_memo / r_e_memo).
//  - Executes store-word writes in a single cycle.
//  - Returns load-word data after a fixed read latency, flagged by a one-cycle r_valid pulse.
//  - Reports busy while a read is in flight.
//  - Reports illegal requests on err.
//  - Sits between the ALU result (address), the register file (store data) and the write-back mux (load data).

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the control unit's memory strobes and the
// data-memory responder.
interface data_mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              w_e_memo;
    logic              r_e_memo;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              busy;
    logic              err;

    modport master (
        output w_e_memo, r_e_memo, addr, w_data,
        input  r_data, r_valid, busy, err
    );

    modport slave (
        input  w_e_memo, r_e_memo, addr, w_data,
        output r_data, r_valid, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-cycle stores, fixed-latency loads with a
// one-cycle r_valid pulse, busy while a load is in flight, err on rejects.
// Optional feature macro: DMEM_WR_WHILE_BUSY_EN (accept legal stores while
// busy and forward them into a pending load to the same address).
module data_mem_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] raddr, raddr_next;
    logic              wr_en_c;
    logic              err_next;
    logic [DATA_W-1:0] resp_data_c;
    logic              req_in_range_c;
    logic              rd_in_range_c;

    logic [DATA_W-1:0] mem [DEPTH];

    assign req_in_range_c = 32'(bus.addr) < DEPTH;
    assign rd_in_range_c  = 32'(raddr_next) < DEPTH;

    // State, latency counter and latched read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            raddr <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            raddr <= raddr_next;
        end
    end

    // Next-state, write enable and error decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        raddr_next = raddr;
        wr_en_c    = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.w_e_memo && bus.r_e_memo) begin
                    err_next = 1'b1;
                end else if (bus.w_e_memo) begin
                    if (req_in_range_c) wr_en_c  = 1'b1;
                    else                err_next = 1'b1;
                end else if (bus.r_e_memo) begin
                    raddr_next = bus.addr;
                    if (RD_LAT == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            WAIT, RESP: begin
                if (state == WAIT) begin
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_next = RESP;
                end else begin
                    state_next = IDLE;
                end
`ifdef DMEM_WR_WHILE_BUSY_EN
                if (bus.r_e_memo) begin
                    err_next = 1'b1;
                end else if (bus.w_e_memo) begin
                    if (req_in_range_c) wr_en_c  = 1'b1;
                    else                err_next = 1'b1;
                end
`else
                if (bus.w_e_memo || bus.r_e_memo) err_next = 1'b1;
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Response word: out-of-range reads return 0, a same-edge store is forwarded.
    always_comb begin
        resp_data_c = '0;
        if (wr_en_c && (bus.addr == raddr_next)) begin
            resp_data_c = bus.w_data;
        end else if (rd_in_range_c) begin
            resp_data_c = mem[raddr_next[IDX_W-1:0]];
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r_data  <= '0;
            bus.r_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.r_valid <= (state_next == RESP);
            bus.busy    <= (state_next != IDLE);
            bus.err     <= err_next;
            if (state_next == RESP) bus.r_data <= resp_data_c;
        end
    end

    // Memory array, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (wr_en_c) begin
            mem[bus.addr[IDX_W-1:0]] <= bus.w_data;
        end
    end
endmodule
